// File: rtl/tower_slot_scheduler_pkg.sv
// Shared types and default geometry for the tower slot scheduler.
package tower_pkg;

  localparam int unsigned COORD_W     = 11;
  localparam int unsigned DEF_TOWER_W = 56;
  localparam int unsigned DEF_TOWER_H = 116;
  localparam int unsigned DEF_X_BIAS  = 11;
  localparam int unsigned DEF_Y_BIAS  = 9;

  typedef enum logic {
    OP_PLACE  = 1'b0,
    OP_REMOVE = 1'b1
  } cmd_op_t;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } tower_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2,
    ST_DONE    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tower_hit_detect.sv
// Combinational rectangle hit test for one slot; also returns the raw pixel offsets.
module tower_hit_detect
  import tower_pkg::*;
#(
  parameter int unsigned TOWER_W = DEF_TOWER_W,
  parameter int unsigned TOWER_H = DEF_TOWER_H
) (
  input  tower_slot_t        i_slot,
  input  logic [COORD_W-1:0] i_pixel_x,
  input  logic [COORD_W-1:0] i_pixel_y,
  output logic               o_hit,
  output logic [COORD_W-1:0] o_dx,
  output logic [COORD_W-1:0] o_dy
);

  logic [COORD_W:0] w_end_x;
  logic [COORD_W:0] w_end_y;

  // One extra bit on the far edge keeps towers near the 11-bit limit from wrapping.
  assign w_end_x = {1'b0, i_slot.x} + (COORD_W+1)'(TOWER_W);
  assign w_end_y = {1'b0, i_slot.y} + (COORD_W+1)'(TOWER_H);

  assign o_hit = i_slot.active
               & (i_pixel_x >= i_slot.x) & ({1'b0, i_pixel_x} < w_end_x)
               & (i_pixel_y >= i_slot.y) & ({1'b0, i_pixel_y} < w_end_y);

  assign o_dx = i_pixel_x - i_slot.x;
  assign o_dy = i_pixel_y - i_slot.y;

endmodule

// File: rtl/tower_slot_scheduler.sv
// Slot table, frame-aligned command FSM and lowest-index-wins selection feeding one tower bitmap.
module tower_slot_scheduler
  import tower_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SCREEN_W  = 640,
  parameter int unsigned SCREEN_H  = 480,
  parameter int unsigned TOWER_W   = DEF_TOWER_W,
  parameter int unsigned TOWER_H   = DEF_TOWER_H,
  parameter int unsigned X_BIAS    = DEF_X_BIAS,
  parameter int unsigned Y_BIAS    = DEF_Y_BIAS,
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [SLOT_W-1:0]  cmd_slot,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  output logic               cmd_done,
  output logic               cmd_error,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               InsideRectangle,
  output logic [SLOT_W-1:0]  hitSlot,
  output logic [SLOT_W:0]    towerCount
);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  cmd_op_t            r_op;
  logic [SLOT_W-1:0]  r_slot;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_done;
  logic               r_error;
  logic [SLOT_W:0]    r_count;
  tower_slot_t        r_table [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] w_hit;
  logic [COORD_W-1:0]   w_dx [NUM_SLOTS];
  logic [COORD_W-1:0]   w_dy [NUM_SLOTS];
  logic                 w_any;
  logic                 w_take;
  logic [SLOT_W-1:0]    w_win;
  logic [COORD_W-1:0]   w_sel_dx;
  logic [COORD_W-1:0]   w_sel_dy;
  logic                 w_out_of_screen;
  logic                 w_reject;

  logic [COORD_W-1:0] r_offset_x;
  logic [COORD_W-1:0] r_offset_y;
  logic               r_inside;
  logic [SLOT_W-1:0]  r_hit_slot;

  localparam logic [SLOT_W:0] COUNT_ONE = {{SLOT_W{1'b0}}, 1'b1};

  assign w_out_of_screen = (({1'b0, r_x} + (COORD_W+1)'(TOWER_W)) > (COORD_W+1)'(SCREEN_W))
                         | (({1'b0, r_y} + (COORD_W+1)'(TOWER_H)) > (COORD_W+1)'(SCREEN_H));
  assign w_reject = (r_op == OP_PLACE) ? (r_table[r_slot].active | w_out_of_screen)
                                       : ~r_table[r_slot].active;

  // Command FSM next state; the accept cycle is IDLE, so a coincident startOfFrame is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    w_state_nxt = cmd_valid ? ST_PENDING : ST_IDLE;
      ST_PENDING: w_state_nxt = startOfFrame ? ST_APPLY : ST_PENDING;
      ST_APPLY:   w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, latched command and completion status.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_PLACE;
      r_slot  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_op   <= cmd_op_t'(cmd_op);
        r_slot <= cmd_slot;
        r_x    <= cmd_x;
        r_y    <= cmd_y;
      end
      r_done  <= (r_state == ST_APPLY);
      r_error <= (r_state == ST_APPLY) & w_reject;
      if (r_state == ST_APPLY && !w_reject) begin
        r_count <= (r_op == OP_PLACE) ? (r_count + COUNT_ONE) : (r_count - COUNT_ONE);
      end
    end
  end

  // Slot table; only written in APPLY, which is the cycle after startOfFrame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_table[i] <= '0;
      end
    end else if (r_state == ST_APPLY && !w_reject) begin
      if (r_op == OP_PLACE) begin
        r_table[r_slot] <= '{active: 1'b1, x: r_x, y: r_y};
      end else begin
        r_table[r_slot].active <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
    tower_hit_detect #(
      .TOWER_W (TOWER_W),
      .TOWER_H (TOWER_H)
    ) u_hit (
      .i_slot    (r_table[g]),
      .i_pixel_x (pixelX),
      .i_pixel_y (pixelY),
      .o_hit     (w_hit[g]),
      .o_dx      (w_dx[g]),
      .o_dy      (w_dy[g])
    );
  end

  // Priority encoder: the first hitting slot in ascending order wins.
  always_comb begin
    w_any    = 1'b0;
    w_take   = 1'b0;
    w_win    = '0;
    w_sel_dx = '0;
    w_sel_dy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_take   = w_hit[i] & ~w_any;
      w_win    = w_take ? SLOT_W'(i) : w_win;
      w_sel_dx = w_take ? w_dx[i] : w_sel_dx;
      w_sel_dy = w_take ? w_dy[i] : w_sel_dy;
      w_any    = w_any | w_hit[i];
    end
  end

  // Registered hit outputs, zeroed when no tower covers the pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inside   <= 1'b0;
      r_hit_slot <= '0;
      r_offset_x <= '0;
      r_offset_y <= '0;
    end else begin
      r_inside   <= w_any;
      r_hit_slot <= w_win;
      r_offset_x <= w_any ? (w_sel_dx + COORD_W'(X_BIAS)) : '0;
      r_offset_y <= w_any ? (w_sel_dy + COORD_W'(Y_BIAS)) : '0;
    end
  end

  assign cmd_ready       = (r_state == ST_IDLE) & ~reset;
  assign cmd_done        = r_done;
  assign cmd_error       = r_error;
  assign offsetX         = r_offset_x;
  assign offsetY         = r_offset_y;
  assign InsideRectangle = r_inside;
  assign hitSlot         = r_hit_slot;
  assign towerCount      = r_count;

endmodule
